// File: rtl/button_cond_pkg.sv
// Shared types and counter-width helpers for the button conditioner.
`timescale 1ns/1ps
package button_cond_pkg;

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    function automatic int unsigned dcnt_width(input int unsigned debounce_cycles);
        return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
    endfunction

    // Long-press counter saturates at LONG_CYCLES, so it must hold that value.
    function automatic int unsigned lcnt_width(input int unsigned long_cycles);
        return $clog2(long_cycles + 1);
    endfunction

    typedef struct packed {
        logic press;
        logic released;
        logic long_press;
    } btn_evt_t;

endpackage

// File: rtl/btn_chan_conditioner.sv
// One channel: pin synchroniser, symmetric debounce, long-press timer and
// registered one-cycle event pulses.
`timescale 1ns/1ps
module btn_chan_conditioner
    import button_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter logic        ACTIVE_LOW      = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_i,
    output logic     level_o,
    output btn_evt_t evt_o
);

    localparam int unsigned DCNT_W = dcnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned LCNT_W = lcnt_width(LONG_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_PRE  = LCNT_W'(LONG_CYCLES - 1);

    // The chain carries the raw pin so reset can preload the inactive pin level.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              level_q, level_d;
    logic              level_dly_q, level_dly_d;
    btn_evt_t          evt_q, evt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
        s      = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    end

    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d = s;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        lcnt_d = '0;
        if (level_q) begin
            lcnt_d = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + 1'b1;
        end
    end

    always_comb begin
        level_dly_d      = level_q;
        evt_d.press      = level_q & ~level_dly_q;
        evt_d.released   = ~level_q & level_dly_q;
        evt_d.long_press = level_q & (lcnt_q == LCNT_PRE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{ACTIVE_LOW}};
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            evt_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            evt_q       <= evt_d;
        end
    end

    assign level_o = level_q;
    assign evt_o   = evt_q;

endmodule

// File: rtl/multi_button_conditioner.sv
// N-channel button conditioner: independent per-channel sync/debounce/events.
// The release-event port is named 'released' because 'release' is a reserved word.
`timescale 1ns/1ps
module multi_button_conditioner
    import button_cond_pkg::*;
#(
    parameter int unsigned       NUM_CH          = 1,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       LONG_CYCLES     = 50000000,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] released,
    output logic [NUM_CH-1:0] long_press
);

    btn_evt_t evt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_chan_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW[i])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn[i]),
            .level_o (level[i]),
            .evt_o   (evt[i])
        );

        assign press[i]      = evt[i].press;
        assign released[i]   = evt[i].released;
        assign long_press[i] = evt[i].long_press;
    end

endmodule

// File: tb/tb_multi_button_conditioner.sv
// Randomised and directed bench for multi_button_conditioner against a
// sample-window reference model.
`timescale 1ns/1ps
module tb_multi_button_conditioner;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int DB  = 8;
    localparam int LG  = 32;
    localparam logic [NCH-1:0] AL = 4'b0010;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] level, press, released, long_press;

    multi_button_conditioner #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .ACTIVE_LOW      (AL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .level      (level),
        .press      (press),
        .released   (released),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: level flips once the DB synchronised samples seen by the
    // debouncer (pin values SS..SS+DB-1 edges old) all disagree with it.
    logic [NCH-1:0] m_level = '0, m_lvd = '0, m_press = '0, m_rel = '0, m_lp = '0;
    int             streak [NCH];
    bit             win [NCH][$];
    int             n_press [NCH];
    int             n_rel [NCH];
    int             n_lp [NCH];
    int             cd [NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] eff;
        bit             flip;
        logic           nl;
        eff = btn ^ AL;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!rst_n) begin
                win[ch].delete();
                for (int k = 0; k < SS + DB; k++) win[ch].push_back(1'b0);
                streak[ch]  = 0;
                m_level[ch] = 1'b0;
                m_lvd[ch]   = 1'b0;
                m_press[ch] = 1'b0;
                m_rel[ch]   = 1'b0;
                m_lp[ch]    = 1'b0;
            end else begin
                m_press[ch] = m_level[ch] & ~m_lvd[ch];
                m_rel[ch]   = ~m_level[ch] & m_lvd[ch];
                m_lp[ch]    = (streak[ch] == LG);
                win[ch].push_back(eff[ch]);
                void'(win[ch].pop_front());
                flip = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (win[ch][k] == m_level[ch]) flip = 1'b0;
                nl = flip ? ~m_level[ch] : m_level[ch];
                if (!nl) streak[ch] = 0;
                else if (streak[ch] < (1 << 20)) streak[ch]++;
                m_lvd[ch]   = m_level[ch];
                m_level[ch] = nl;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("press", 32'(press), 32'(m_press));
        check_eq("release", 32'(released), 32'(m_rel));
        check_eq("long_press", 32'(long_press), 32'(m_lp));
        for (int ch = 0; ch < NCH; ch++) begin
            n_press[ch] += int'(press[ch]);
            n_rel[ch]   += int'(released[ch]);
            n_lp[ch]    += int'(long_press[ch]);
        end
    endtask

    // First cycle (1-based) on which each event is seen on one channel; -1 if never.
    task automatic watch(input int ch, input int cycles, output int t_lvl,
                         output int t_prs, output int t_rel, output int t_lp);
        logic start;
        start = level[ch];
        t_lvl = -1; t_prs = -1; t_rel = -1; t_lp = -1;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            if (t_lvl < 0 && level[ch] != start) t_lvl = c;
            if (t_prs < 0 && press[ch])          t_prs = c;
            if (t_rel < 0 && released[ch])       t_rel = c;
            if (t_lp  < 0 && long_press[ch])     t_lp  = c;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int tl, tp, tr, tq, base, hit;
        for (int ch = 0; ch < NCH; ch++) begin
            streak[ch] = 0; n_press[ch] = 0; n_rel[ch] = 0; n_lp[ch] = 0;
        end

        // Reset with idle pins, then hold idle.
        rst_n = 1'b0;
        btn   = AL;
        repeat (3) tick();
        check_eq("reset_outputs", 32'({level, press, released, long_press}), 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check_eq("idle_outputs", 32'({level, press, released, long_press}), 32'd0);

        // Clean press on ch0.
        btn[0] = 1'b1;
        watch(0, 30, tl, tp, tr, tq);
        check_eq("ch0_level_latency", 32'(tl), 32'd10);
        check_eq("ch0_press_latency", 32'(tp), 32'd11);
        btn[0] = 1'b0;
        watch(0, 30, tl, tp, tr, tq);
        check_eq("ch0_release_latency", 32'(tr), 32'd11);

        // Bounced press and release on ch2.
        base = n_press[2];
        for (int k = 0; k < 12; k++) begin
            btn[2] = ~btn[2];
            repeat (3) tick();
        end
        btn[2] = 1'b1;
        watch(2, 30, tl, tp, tr, tq);
        check_eq("ch2_bounce_level_latency", 32'(tl), 32'd10);
        check_eq("ch2_bounce_press_count", 32'(n_press[2] - base), 32'd1);
        base = n_rel[2];
        for (int k = 0; k < 12; k++) begin
            btn[2] = ~btn[2];
            repeat (3) tick();
        end
        btn[2] = 1'b0;
        watch(2, 30, tl, tp, tr, tq);
        check_eq("ch2_bounce_fall_latency", 32'(tl), 32'd10);
        check_eq("ch2_bounce_release_count", 32'(n_rel[2] - base), 32'd1);

        // Active-low ch1.
        btn[1] = 1'b0;
        watch(1, 20, tl, tp, tr, tq);
        check_eq("ch1_press_latency", 32'(tp), 32'd11);
        btn[1] = 1'b1;
        watch(1, 20, tl, tp, tr, tq);
        check_eq("ch1_release_latency", 32'(tr), 32'd11);

        // Long press on ch3, then a short hold.
        base = n_lp[3];
        btn[3] = 1'b1;
        watch(3, 70, tl, tp, tr, tq);
        check_eq("ch3_long_after_level", 32'(tq - tl), 32'd32);
        check_eq("ch3_long_count", 32'(n_lp[3] - base), 32'd1);
        btn[3] = 1'b0;
        repeat (20) tick();
        base = n_lp[3];
        btn[3] = 1'b1;
        repeat (SS + DB + 20) tick();
        btn[3] = 1'b0;
        repeat (20) tick();
        check_eq("ch3_short_no_long", 32'(n_lp[3] - base), 32'd0);

        // Simultaneous presses on ch0 and ch3.
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        hit = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (hit < 0 && (press & 4'b1001) != 4'b0000) begin
                hit = c;
                check_eq("simul_press_bits", 32'(press & 4'b1001), 32'h9);
            end
        end
        check_eq("simul_press_latency", 32'(hit), 32'd11);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        repeat (20) tick();

        // Reset while ch0 is pressed.
        btn[0] = 1'b1;
        repeat (20) tick();
        base = n_rel[0];
        rst_n = 1'b0;
        repeat (2) tick();
        check_eq("rst_mid_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        watch(0, 20, tl, tp, tr, tq);
        check_eq("rst_mid_no_release", 32'(n_rel[0] - base), 32'd0);
        check_eq("rst_mid_repress_latency", 32'(tp), 32'd11);

        // Random pin activity with occasional resets.
        for (int ch = 0; ch < NCH; ch++) cd[ch] = $urandom_range(1, 60);
        repeat (4000) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cd[ch]--;
                if (cd[ch] == 0) begin
                    btn[ch] = ~btn[ch];
                    cd[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 70);
                end
            end
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
